tp_frame_sequencer: RTL and testbench

Frame-synchronous controller for the test pattern generator. Drives the generator's pattern mode, single-colour value, timing parameters and sync polarities from a 4-entry resolution preset table. Applies every change only at a frame boundary, and restarts the generator cleanly when the resolution changes. Sits directly above the generator; its only feedback from the generator is the generator's VS output.

---
 rtl/tp_frame_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_tp_frame_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tp_frame_sequencer.sv
// tp_frame_sequencer: frame-synchronous controller for the test pattern generator.
// Holds pattern mode, single-colour index and resolution preset, and applies every change on
// the sync leading edge of the generator's own VS. A preset change restarts the generator
// through a registered active-low reset held for RESYNC_CYCLES cycles.
//
// Ports:
//   I_pxl_clk, I_rst_n      pixel clock, asynchronous active-low reset
//   I_vs                    generator VS, polarity given by O_vs_pol
//   I_enable, I_auto        allow stepping / advance every FRAMES_PER_STEP frames
//   I_step, I_load          one-cycle advance request / load of I_mode_req + I_preset_req
//   O_gen_rst_n             registered active-low reset to the generator
//   O_mode, O_single_*      pattern mode and single-colour value
//   O_h_* / O_v_*           generator timing of the active preset
//   O_hs_pol, O_vs_pol      1 = positive sync
//   O_preset, O_frame_cnt   active preset, frames since last resync
//   O_switch                one-cycle pulse when a new configuration takes effect
module tp_frame_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 60,
  parameter int unsigned RESYNC_CYCLES   = 4
) (
  input  logic        I_pxl_clk,
  input  logic        I_rst_n,
  input  logic        I_vs,
  input  logic        I_enable,
  input  logic        I_auto,
  input  logic        I_step,
  input  logic        I_load,
  input  logic [2:0]  I_mode_req,
  input  logic [1:0]  I_preset_req,
  output logic        O_gen_rst_n,
  output logic [2:0]  O_mode,
  output logic [7:0]  O_single_r,
  output logic [7:0]  O_single_g,
  output logic [7:0]  O_single_b,
  output logic [11:0] O_h_total,
  output logic [11:0] O_h_sync,
  output logic [11:0] O_h_bporch,
  output logic [11:0] O_h_res,
  output logic [11:0] O_v_total,
  output logic [11:0] O_v_sync,
  output logic [11:0] O_v_bporch,
  output logic [11:0] O_v_res,
  output logic        O_hs_pol,
  output logic        O_vs_pol,
  output logic [1:0]  O_preset,
  output logic [15:0] O_frame_cnt,
  output logic        O_switch
);

  localparam logic [15:0] FpsLast = 16'(FRAMES_PER_STEP - 1);
  localparam logic [3:0]  RsLast  = 4'(RESYNC_CYCLES);

  typedef enum logic [1:0] {StResync, StRun, StPend} state_e;

  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        pol;
  } timing_t;

  function automatic timing_t preset_lut(input logic [1:0] p);
    timing_t t;
    unique case (p)
      2'd0: t = '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0};
      2'd1: t = '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1};
      2'd2: t = '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1};
      default: t = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0};
    endcase
    return t;
  endfunction

  state_e      state_q;
  logic [3:0]  rcnt_q;
  logic        gen_rst_n_q;
  logic [2:0]  mode_q;
  logic [2:0]  col_q;
  logic [1:0]  preset_q;
  timing_t     tim_q;
  logic [15:0] fcnt_q;
  logic        switch_q;
  logic        raw_vs_q;
  logic        raw_vs_qq;
  logic        bnd_q;
  logic        pend_load_q;
  logic        pend_step_q;
  logic [2:0]  mode_req_q;
  logic [1:0]  preset_req_q;

  logic        live_bnd;
  logic        auto_fire;
  logic        step_req;
  logic [2:0]  adv_mode;
  logic [2:0]  adv_col;

  // Boundaries during resync are ignored; the VS pipeline may carry a polarity-change glitch.
  assign live_bnd  = bnd_q && (state_q != StResync);
  assign auto_fire = live_bnd && I_enable && I_auto && (fcnt_q == FpsLast);
  // A load in the same cycle wins over a step.
  assign step_req  = I_step && I_enable && !I_load;

  // Modes 4..7 behave as single colour (mode 3).
  always_comb begin
    adv_mode = mode_q;
    adv_col  = col_q;
    if (mode_q < 3'd3) begin
      adv_mode = mode_q + 3'd1;
    end else if (col_q != 3'd7) begin
      adv_col = col_q + 3'd1;
    end else begin
      adv_mode = 3'd0;
      adv_col  = 3'd0;
    end
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= StResync;
      rcnt_q       <= 4'd1;  // first post-reset edge already counts as a resync cycle
      gen_rst_n_q  <= 1'b0;
      mode_q       <= 3'd0;
      col_q        <= 3'd0;
      preset_q     <= 2'd0;
      tim_q        <= preset_lut(2'd0);
      fcnt_q       <= 16'd0;
      switch_q     <= 1'b0;
      raw_vs_q     <= 1'b0;
      raw_vs_qq    <= 1'b0;
      bnd_q        <= 1'b0;
      pend_load_q  <= 1'b0;
      pend_step_q  <= 1'b0;
      mode_req_q   <= 3'd0;
      preset_req_q <= 2'd0;
    end else begin
      // raw_vs is 0 inside sync for either polarity, so its falling edge is the boundary.
      raw_vs_q  <= I_vs ^ tim_q.pol;
      raw_vs_qq <= raw_vs_q;
      bnd_q     <= raw_vs_qq & ~raw_vs_q;
      switch_q  <= 1'b0;

      if (live_bnd && I_enable) begin
        if (auto_fire) fcnt_q <= 16'd0;
        else           fcnt_q <= fcnt_q + 16'd1;
      end

      case (state_q)
        StResync: begin
          if (rcnt_q == RsLast) begin
            gen_rst_n_q <= 1'b1;
            fcnt_q      <= 16'd0;
            state_q     <= StRun;
          end else begin
            gen_rst_n_q <= 1'b0;
            rcnt_q      <= rcnt_q + 4'd1;
          end
        end
        StRun: begin
          if (pend_load_q || pend_step_q) state_q <= StPend;
        end
        StPend: begin
          if (live_bnd) begin
            state_q <= StRun;
            if (pend_load_q) begin
              pend_load_q <= 1'b0;
              mode_q      <= mode_req_q;
              col_q       <= 3'd0;
              switch_q    <= 1'b1;
              if (preset_req_q != preset_q) begin
                preset_q <= preset_req_q;
                tim_q    <= preset_lut(preset_req_q);
                fcnt_q   <= 16'd0;
                rcnt_q   <= 4'd0;  // first cycle keeps the generator running on the new timing
                state_q  <= StResync;
              end
            end else if (pend_step_q && I_enable) begin
              pend_step_q <= 1'b0;
              mode_q      <= adv_mode;
              col_q       <= adv_col;
              switch_q    <= 1'b1;
            end
          end
        end
        default: state_q <= StResync;
      endcase

      // New requests take priority over the clear of an item applied this cycle.
      if (I_load) begin
        pend_load_q  <= 1'b1;
        mode_req_q   <= I_mode_req;
        preset_req_q <= I_preset_req;
      end
      if (step_req || auto_fire) pend_step_q <= 1'b1;
      if (!I_enable)             pend_step_q <= 1'b0;
    end
  end

  // Colour order WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK reduces to inverted bits.
  assign O_single_r  = {8{~col_q[1]}};
  assign O_single_g  = {8{~col_q[2]}};
  assign O_single_b  = {8{~col_q[0]}};

  assign O_gen_rst_n = gen_rst_n_q;
  assign O_mode      = mode_q;
  assign O_h_total   = tim_q.h_total;
  assign O_h_sync    = tim_q.h_sync;
  assign O_h_bporch  = tim_q.h_bporch;
  assign O_h_res     = tim_q.h_res;
  assign O_v_total   = tim_q.v_total;
  assign O_v_sync    = tim_q.v_sync;
  assign O_v_bporch  = tim_q.v_bporch;
  assign O_v_res     = tim_q.v_res;
  assign O_hs_pol    = tim_q.pol;
  assign O_vs_pol    = tim_q.pol;
  assign O_preset    = preset_q;
  assign O_frame_cnt = fcnt_q;
  assign O_switch    = switch_q;

endmodule

// File: tb/tb_tp_frame_sequencer.sv
// Testbench for tp_frame_sequencer: free-running VS source, scoreboard of expected
// configurations popped on every O_switch pulse, plus per-scenario inline checks.
module tb_tp_frame_sequencer;
  localparam int unsigned Fps      = 2;
  localparam int unsigned Rs       = 4;
  localparam int          FrameLen = 16;

  logic        I_pxl_clk, I_rst_n, I_vs, I_enable, I_auto, I_step, I_load;
  logic [2:0]  I_mode_req;
  logic [1:0]  I_preset_req;
  logic        O_gen_rst_n, O_hs_pol, O_vs_pol, O_switch;
  logic [2:0]  O_mode;
  logic [7:0]  O_single_r, O_single_g, O_single_b;
  logic [11:0] O_h_total, O_h_sync, O_h_bporch, O_h_res;
  logic [11:0] O_v_total, O_v_sync, O_v_bporch, O_v_res;
  logic [1:0]  O_preset;
  logic [15:0] O_frame_cnt;

  typedef struct packed {
    logic [2:0] mode;
    logic [2:0] col;
    logic [1:0] preset;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   sw_seen  = 0;
  int   vs_phase = 0;
  logic tb_pol   = 1'b0;

  logic [97:0] dut_tim;
  logic [23:0] dut_rgb;
  assign dut_tim = {O_h_total, O_h_sync, O_h_bporch, O_h_res,
                    O_v_total, O_v_sync, O_v_bporch, O_v_res, O_hs_pol, O_vs_pol};
  assign dut_rgb = {O_single_r, O_single_g, O_single_b};

  tp_frame_sequencer #(
    .FRAMES_PER_STEP(Fps),
    .RESYNC_CYCLES  (Rs)
  ) dut (
    .I_pxl_clk   (I_pxl_clk),
    .I_rst_n     (I_rst_n),
    .I_vs        (I_vs),
    .I_enable    (I_enable),
    .I_auto      (I_auto),
    .I_step      (I_step),
    .I_load      (I_load),
    .I_mode_req  (I_mode_req),
    .I_preset_req(I_preset_req),
    .O_gen_rst_n (O_gen_rst_n),
    .O_mode      (O_mode),
    .O_single_r  (O_single_r),
    .O_single_g  (O_single_g),
    .O_single_b  (O_single_b),
    .O_h_total   (O_h_total),
    .O_h_sync    (O_h_sync),
    .O_h_bporch  (O_h_bporch),
    .O_h_res     (O_h_res),
    .O_v_total   (O_v_total),
    .O_v_sync    (O_v_sync),
    .O_v_bporch  (O_v_bporch),
    .O_v_res     (O_v_res),
    .O_hs_pol    (O_hs_pol),
    .O_vs_pol    (O_vs_pol),
    .O_preset    (O_preset),
    .O_frame_cnt (O_frame_cnt),
    .O_switch    (O_switch)
  );

  function automatic logic [23:0] exp_rgb(input logic [2:0] c);
    case (c)
      3'd0:    return 24'hFFFFFF;  // white
      3'd1:    return 24'hFFFF00;  // yellow
      3'd2:    return 24'h00FFFF;  // cyan
      3'd3:    return 24'h00FF00;  // green
      3'd4:    return 24'hFF00FF;  // magenta
      3'd5:    return 24'hFF0000;  // red
      3'd6:    return 24'h0000FF;  // blue
      default: return 24'h000000;  // black
    endcase
  endfunction

  function automatic logic [97:0] exp_tim(input logic [1:0] p);
    case (p)
      2'd0: return {12'd800, 12'd96, 12'd48, 12'd640, 12'd525, 12'd2, 12'd33, 12'd480, 2'b00};
      2'd1: return {12'd1056, 12'd128, 12'd88, 12'd800, 12'd628, 12'd4, 12'd23, 12'd600, 2'b11};
      2'd2: return {12'd1650, 12'd40, 12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 2'b11};
      default:
        return {12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 2'b00};
    endcase
  endfunction

  initial begin
    I_pxl_clk = 1'b0;
    forever #5 I_pxl_clk = ~I_pxl_clk;
  end

  // VS source: 3-cycle sync pulse every FrameLen cycles, polarity tracked by tb_pol.
  initial begin
    I_vs = 1'b1;
    forever begin
      @(negedge I_pxl_clk);
      vs_phase = (vs_phase == FrameLen - 1) ? 0 : vs_phase + 1;
      I_vs = (vs_phase < 3) ? tb_pol : ~tb_pol;
    end
  end

  // Scoreboard: every O_switch pulse must match the oldest expected configuration.
  initial begin
    forever begin
      @(negedge I_pxl_clk);
      if (I_rst_n === 1'b1 && O_switch === 1'b1) begin
        sw_seen++;
        chk_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_switch got mode=%0d preset=%0d want no switch",
                   O_mode, O_preset);
        end else begin
          mon_e = sb.pop_front();
          if (O_mode !== mon_e.mode || dut_rgb !== exp_rgb(mon_e.col) ||
              O_preset !== mon_e.preset || dut_tim !== exp_tim(mon_e.preset))
            $display("FAIL switch_%0d got mode=%0d rgb=%h preset=%0d tim=%h want mode=%0d rgb=%h preset=%0d tim=%h",
                     sw_seen, O_mode, dut_rgb, O_preset, dut_tim, mon_e.mode,
                     exp_rgb(mon_e.col), mon_e.preset, exp_tim(mon_e.preset));
          else pass_cnt++;
        end
      end
    end
  end

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * FrameLen; i++) begin
      @(posedge I_pxl_clk);
      if (vs_phase == p) break;
    end
  endtask

  task automatic wait_switch(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge I_pxl_clk);
      if (O_switch === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_req(input bit ld, input bit st, input logic [2:0] m, input logic [1:0] p);
    @(negedge I_pxl_clk);
    I_load = ld; I_step = st; I_mode_req = m; I_preset_req = p;
    @(negedge I_pxl_clk);
    I_load = 1'b0; I_step = 1'b0;
  endtask

  task automatic test_reset();
    int low;
    I_rst_n = 1'b0;
    repeat (2) @(negedge I_pxl_clk);
    chk_cnt++; if (O_gen_rst_n !== 1'b0) $display("FAIL rst_gen got %b want 0", O_gen_rst_n); else pass_cnt++;
    chk_cnt++; if (O_mode !== 3'd0) $display("FAIL rst_mode got %0d want 0", O_mode); else pass_cnt++;
    chk_cnt++; if (dut_rgb !== 24'hFFFFFF) $display("FAIL rst_rgb got %h want ffffff", dut_rgb); else pass_cnt++;
    chk_cnt++; if (O_preset !== 2'd0) $display("FAIL rst_preset got %0d want 0", O_preset); else pass_cnt++;
    chk_cnt++; if (dut_tim !== exp_tim(2'd0)) $display("FAIL rst_tim got %h want %h", dut_tim, exp_tim(2'd0)); else pass_cnt++;
    chk_cnt++; if (O_frame_cnt !== 16'd0) $display("FAIL rst_fcnt got %0d want 0", O_frame_cnt); else pass_cnt++;
    chk_cnt++; if (O_switch !== 1'b0) $display("FAIL rst_switch got %b want 0", O_switch); else pass_cnt++;
    I_rst_n = 1'b1;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      if (O_gen_rst_n === 1'b1) break;
      low++;
      @(negedge I_pxl_clk);
    end
    chk_cnt++; if (low != Rs) $display("FAIL rst_hold_cycles got %0d want %0d", low, Rs); else pass_cnt++;
    chk_cnt++; if (dut_tim !== exp_tim(2'd0)) $display("FAIL run_tim got %h want %h", dut_tim, exp_tim(2'd0)); else pass_cnt++;
  endtask

  task automatic test_auto();
    int sw0;
    sw0 = sw_seen;
    sb.push_back(sb_t'{3'd1, 3'd0, 2'd0});
    sb.push_back(sb_t'{3'd2, 3'd0, 2'd0});
    for (int k = 0; k < 8; k++) sb.push_back(sb_t'{3'd3, 3'(k), 2'd0});
    sb.push_back(sb_t'{3'd0, 3'd0, 2'd0});
    @(negedge I_pxl_clk);
    I_enable = 1'b1; I_auto = 1'b1;
    for (int i = 0; i < 40 * FrameLen; i++) begin
      @(negedge I_pxl_clk);
      if (sb.size() == 0) break;
    end
    I_auto = 1'b0; I_enable = 1'b0;
    chk_cnt++; if (sb.size() != 0) $display("FAIL auto_drain got %0d left want 0", sb.size()); else pass_cnt++;
    chk_cnt++; if (sw_seen - sw0 != 11) $display("FAIL auto_pulses got %0d want 11", sw_seen - sw0); else pass_cnt++;
  endtask

  task automatic test_load_preset();
    bit got;
    int low;
    wait_phase(8);
    pulse_req(1'b1, 1'b0, 3'd2, 2'd2);
    sb.push_back(sb_t'{3'd2, 3'd0, 2'd2});
    repeat (3) @(negedge I_pxl_clk);
    chk_cnt++; if (O_mode !== 3'd0 || O_h_total !== 12'd800) $display("FAIL load_early got mode=%0d ht=%0d want mode=0 ht=800", O_mode, O_h_total); else pass_cnt++;
    wait_switch(3 * FrameLen, got);
    tb_pol = 1'b1;
    chk_cnt++; if (!got) $display("FAIL load_timeout got no switch want switch"); else pass_cnt++;
    chk_cnt++; if (O_gen_rst_n !== 1'b1) $display("FAIL load_gen_at_switch got %b want 1", O_gen_rst_n); else pass_cnt++;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge I_pxl_clk);
      if (O_gen_rst_n === 1'b1) break;
      low++;
    end
    chk_cnt++; if (low != Rs) $display("FAIL load_resync_cycles got %0d want %0d", low, Rs); else pass_cnt++;
    chk_cnt++; if (O_frame_cnt !== 16'd0) $display("FAIL load_fcnt got %0d want 0", O_frame_cnt); else pass_cnt++;
  endtask

  task automatic test_load_same();
    bit got;
    int low;
    wait_phase(8);
    pulse_req(1'b1, 1'b0, 3'd3, 2'd2);
    sb.push_back(sb_t'{3'd3, 3'd0, 2'd2});
    wait_switch(3 * FrameLen, got);
    chk_cnt++; if (!got) $display("FAIL same_timeout got no switch want switch"); else pass_cnt++;
    low = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge I_pxl_clk);
      if (O_gen_rst_n !== 1'b1) low++;
    end
    chk_cnt++; if (low != 0) $display("FAIL same_no_resync got %0d low cycles want 0", low); else pass_cnt++;
  endtask

  task automatic test_load_step();
    bit got;
    int sw0;
    @(negedge I_pxl_clk);
    I_enable = 1'b1;
    wait_phase(8);
    pulse_req(1'b1, 1'b1, 3'd1, 2'd2);
    sb.push_back(sb_t'{3'd1, 3'd0, 2'd2});
    wait_switch(3 * FrameLen, got);
    chk_cnt++; if (!got) $display("FAIL ldstep_timeout got no switch want switch"); else pass_cnt++;
    sw0 = sw_seen;
    repeat (3 * FrameLen) @(negedge I_pxl_clk);
    chk_cnt++; if (sw_seen != sw0) $display("FAIL ldstep_dropped got %0d extra want 0", sw_seen - sw0); else pass_cnt++;
    wait_phase(8);
    pulse_req(1'b0, 1'b1, 3'd0, 2'd0);
    sb.push_back(sb_t'{3'd2, 3'd0, 2'd2});
    wait_switch(3 * FrameLen, got);
    chk_cnt++; if (!got) $display("FAIL step_timeout got no switch want switch"); else pass_cnt++;
    @(negedge I_pxl_clk);
    I_enable = 1'b0;
    sw0 = sw_seen;
    pulse_req(1'b0, 1'b1, 3'd0, 2'd0);
    repeat (3 * FrameLen) @(negedge I_pxl_clk);
    chk_cnt++; if (sw_seen != sw0 || O_mode !== 3'd2) $display("FAIL step_disabled got sw=%0d mode=%0d want sw=0 mode=2", sw_seen - sw0, O_mode); else pass_cnt++;
  endtask

  task automatic test_reset_pend();
    int sw0;
    wait_phase(8);
    pulse_req(1'b1, 1'b0, 3'd2, 2'd1);
    repeat (2) @(negedge I_pxl_clk);
    I_rst_n = 1'b0;
    #1;
    tb_pol = 1'b0;
    chk_cnt++; if (O_gen_rst_n !== 1'b0) $display("FAIL pend_rst_gen got %b want 0", O_gen_rst_n); else pass_cnt++;
    chk_cnt++; if (O_mode !== 3'd0 || O_preset !== 2'd0) $display("FAIL pend_rst_cfg got mode=%0d preset=%0d want 0 0", O_mode, O_preset); else pass_cnt++;
    chk_cnt++; if (dut_tim !== exp_tim(2'd0)) $display("FAIL pend_rst_tim got %h want %h", dut_tim, exp_tim(2'd0)); else pass_cnt++;
    chk_cnt++; if (dut_rgb !== 24'hFFFFFF || O_switch !== 1'b0) $display("FAIL pend_rst_out got rgb=%h sw=%b want ffffff 0", dut_rgb, O_switch); else pass_cnt++;
    repeat (3) @(negedge I_pxl_clk);
    I_rst_n = 1'b1;
    sw0 = sw_seen;
    repeat (5 * FrameLen) @(negedge I_pxl_clk);
    chk_cnt++; if (sw_seen != sw0) $display("FAIL pend_lost got %0d switches want 0", sw_seen - sw0); else pass_cnt++;
    chk_cnt++; if (O_preset !== 2'd0 || O_gen_rst_n !== 1'b1) $display("FAIL pend_after got preset=%0d gen=%b want 0 1", O_preset, O_gen_rst_n); else pass_cnt++;
  endtask

  initial begin
    I_rst_n = 1'b0; I_enable = 1'b0; I_auto = 1'b0; I_step = 1'b0; I_load = 1'b0;
    I_mode_req = 3'd0; I_preset_req = 2'd0;
    test_reset();
    test_auto();
    test_load_preset();
    test_load_same();
    test_load_step();
    test_reset_pend();
    chk_cnt++; if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
